pll_scan_rd: RTL and testbench

PLL_SCAN_RD -- requirements
Module: pll_scan_rd

---
 rtl/pll_scan_pkg.sv | 13 +
 rtl/pll_scan_rdbank.sv | 35 +++
 rtl/pll_scan_rd.sv | 94 +++++++++
 tb/tb_pll_scan_rd.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/pll_scan_pkg.sv
// Shared definitions for the PLL scan-chain read-back block.
package pll_scan_pkg;

  localparam int unsigned CHAIN_LEN_DEFAULT = 158;
  localparam int unsigned SNAP_BYTES        = 20;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/pll_scan_rdbank.sv
// Byte-addressed read port over the captured PLL snapshot; one-cycle read latency.
module pll_scan_rdbank
  import pll_scan_pkg::*;
(
  input  logic                    i_clk,
  input  logic                    i_reset_n,
  input  logic [8*SNAP_BYTES-1:0] i_snap,
  input  logic [4:0]              i_addr,
  input  logic                    i_select,
  input  logic                    i_rd_req,
  output logic [7:0]              o_data_rd,
  output logic                    o_rd_valid
);

  logic [7:0] rd_byte;

  // Addresses beyond the snapshot fall through to zero.
  always_comb begin
    rd_byte = '0;
    for (int unsigned b = 0; b < SNAP_BYTES; b++) begin
      if (i_addr == 5'(b)) rd_byte = i_snap[8*b +: 8];
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_data_rd  <= '0;
      o_rd_valid <= 1'b0;
    end else begin
      o_rd_valid <= i_select & i_rd_req;
      if (i_select && i_rd_req) o_data_rd <= rd_byte;
    end
  end

endmodule

// File: rtl/pll_scan_rd.sv
// PLL scan-chain read-back: shifts CHAIN_LEN bits out of the PLL into a snapshot.
// Define PLL_SCAN_RD_RESTORE_EN to recirculate scandataout so the PLL config survives.
module pll_scan_rd
  import pll_scan_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = CHAIN_LEN_DEFAULT,
  parameter int unsigned CNT_W     = 8
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_start,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_scanclkena,
  output logic       o_scandata,
  input  logic       i_scandataout,
  input  logic [4:0] i_addr,
  input  logic       i_select,
  input  logic       i_rd_req,
  output logic [7:0] o_data_rd,
  output logic       o_rd_valid
);

  state_t                  state, nxt;
  logic [CNT_W-1:0]        cnt;
  logic [CHAIN_LEN-1:0]    cap;
  logic [CHAIN_LEN-1:0]    snap;
  logic [8*SNAP_BYTES-1:0] snap_pad;
  logic                    last;

  assign last = (cnt == CNT_W'(CHAIN_LEN - 1));

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (i_start) nxt = SHIFT;
      SHIFT:   if (last) nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Status and scan enable are registered from the next state so they line up with it.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state        <= IDLE;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_scanclkena <= 1'b0;
      cnt          <= '0;
      cap          <= '0;
      snap         <= '0;
    end else begin
      state        <= nxt;
      o_busy       <= (nxt != IDLE);
      o_done       <= (nxt == DONE);
      o_scanclkena <= (nxt == SHIFT);
      if (state == IDLE)
        cnt <= '0;
      else if (state == SHIFT && !last)
        cnt <= cnt + 1'b1;
      if (o_scanclkena) cap <= {i_scandataout, cap[CHAIN_LEN-1:1]};
      if (state == DONE) snap <= cap;
    end
  end

`ifdef PLL_SCAN_RD_RESTORE_EN
  // Launched on the falling edge so the PLL shifts back in the very bit it is
  // presenting; a rising-edge flop would rotate the chain by one position.
  always_ff @(negedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) o_scandata <= 1'b0;
    else            o_scandata <= o_scanclkena ? i_scandataout : 1'b0;
  end
`else
  assign o_scandata = 1'b0;
`endif

  always_comb begin
    snap_pad                = '0;
    snap_pad[CHAIN_LEN-1:0] = snap;
  end

  pll_scan_rdbank u_rdbank (
    .i_clk      (i_clk),
    .i_reset_n  (i_reset_n),
    .i_snap     (snap_pad),
    .i_addr     (i_addr),
    .i_select   (i_select),
    .i_rd_req   (i_rd_req),
    .o_data_rd  (o_data_rd),
    .o_rd_valid (o_rd_valid)
  );

endmodule

// File: tb/tb_pll_scan_rd.sv
// Directed bench for pll_scan_rd with a behavioural PLL scan-chain model.
module tb_pll_scan_rd;

  localparam int L = 158;

  logic       i_clk, i_reset_n, i_start;
  logic       o_busy, o_done, o_scanclkena, o_scandata, i_scandataout;
  logic [4:0] i_addr;
  logic       i_select, i_rd_req;
  logic [7:0] o_data_rd;
  logic       o_rd_valid;

  logic [L-1:0] chain, pre;
  logic         load;

  int errors = 0;
  int checks = 0;

  pll_scan_rd dut (
    .i_clk         (i_clk),
    .i_reset_n     (i_reset_n),
    .i_start       (i_start),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_scanclkena  (o_scanclkena),
    .o_scandata    (o_scandata),
    .i_scandataout (i_scandataout),
    .i_addr        (i_addr),
    .i_select      (i_select),
    .i_rd_req      (i_rd_req),
    .o_data_rd     (o_data_rd),
    .o_rd_valid    (o_rd_valid)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // PLL model: bit 0 is presented on scandataout, scandata enters at the top.
  always @(posedge i_clk) begin
    if (load)              chain <= pre;
    else if (o_scanclkena) chain <= {o_scandata, chain[L-1:1]};
  end
  assign i_scandataout = chain[0];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input logic [L-1:0] v, input int b);
    logic [159:0] p;
    p = {2'b00, v};
    return (b < 20) ? p[8*b +: 8] : 8'h00;
  endfunction

  task automatic preload(input logic [L-1:0] v);
    @(negedge i_clk);
    pre  = v;
    load = 1'b1;
    @(negedge i_clk);
    load = 1'b0;
  endtask

  task automatic do_read(input int a, input logic [7:0] exp, input string tag);
    @(negedge i_clk);
    i_addr   = 5'(a);
    i_select = 1'b1;
    i_rd_req = 1'b1;
    @(negedge i_clk);
    i_select = 1'b0;
    i_rd_req = 1'b0;
    chk({tag, "_valid"}, {31'b0, o_rd_valid}, 32'd1);
    chk({tag, "_data"}, {24'b0, o_data_rd}, {24'b0, exp});
    @(negedge i_clk);
    chk({tag, "_vdrop"}, {31'b0, o_rd_valid}, 32'd0);
  endtask

  task automatic read_all(input logic [L-1:0] v, input string tag);
    for (int b = 0; b < 20; b++) do_read(b, exp_byte(v, b), $sformatf("%s_b%0d", tag, b));
  endtask

  // Cycle n of the loop is the n-th clock period after the edge that sampled i_start.
  task automatic readback(input int rst_at, input bit extra_starts, input bit rd_mid,
                          input logic [7:0] old0, input string tag);
    int ena_cnt = 0, done_cnt = 0, done_cyc = -1, first_ena = -1, last_ena = -1;
    @(negedge i_clk);
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    for (int cyc = 1; cyc <= 300; cyc++) begin
      if (o_scanclkena) begin
        ena_cnt++;
        if (first_ena < 0) first_ena = cyc;
        last_ena = cyc;
      end
      if (o_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (rst_at == 0 && cyc == 1)   chk({tag, "_busy1"},   {31'b0, o_busy}, 32'd1);
      if (rst_at == 0 && cyc == 159) chk({tag, "_busy159"}, {31'b0, o_busy}, 32'd1);
      if (rst_at == 0 && cyc == 160) chk({tag, "_busy160"}, {31'b0, o_busy}, 32'd0);
      i_start = extra_starts && (cyc == 50 || cyc == 159);
      if (rd_mid && (cyc == 81 || cyc == 160)) begin
        chk($sformatf("%s_midrd%0d_valid", tag, cyc), {31'b0, o_rd_valid}, 32'd1);
        chk($sformatf("%s_midrd%0d_data", tag, cyc), {24'b0, o_data_rd}, {24'b0, old0});
        i_select = 1'b0;
        i_rd_req = 1'b0;
      end
      if (rd_mid && (cyc == 80 || cyc == 159)) begin
        i_addr   = 5'd0;
        i_select = 1'b1;
        i_rd_req = 1'b1;
      end
      if (rst_at != 0 && cyc == rst_at + 1) i_reset_n = 1'b1;
      if (rst_at != 0 && cyc == rst_at) begin
        i_reset_n = 1'b0;
        #1;
        chk({tag, "_rst_ena"},  {31'b0, o_scanclkena}, 32'd0);
        chk({tag, "_rst_busy"}, {31'b0, o_busy}, 32'd0);
        done_cnt = 0;
      end
      @(negedge i_clk);
    end
    i_start = 1'b0;
    if (rst_at == 0) begin
      chk({tag, "_ena_first"}, 32'(first_ena), 32'd1);
      chk({tag, "_ena_last"},  32'(last_ena),  32'd158);
      chk({tag, "_ena_cnt"},   32'(ena_cnt),   32'd158);
      chk({tag, "_done_cyc"},  32'(done_cyc),  32'd159);
      chk({tag, "_done_cnt"},  32'(done_cnt),  32'd1);
    end else begin
      chk({tag, "_done_cnt"},  32'(done_cnt),  32'd0);
    end
  endtask

  initial begin
    logic [L-1:0] a5, walk, p, exp2;
    logic [159:0] tmp, cpad, epad;

    tmp  = {20{8'hA5}};
    a5   = tmp[L-1:0];
    walk = '0;
    walk[157] = 1'b1;
    tmp  = {5{32'hC3A15E97}};
    p    = tmp[L-1:0];

    i_reset_n = 1'b0;
    i_start   = 1'b0;
    i_addr    = '0;
    i_select  = 1'b0;
    i_rd_req  = 1'b0;
    load      = 1'b0;
    pre       = '0;
    repeat (3) @(negedge i_clk);
    chk("rst_busy",    {31'b0, o_busy},       32'd0);
    chk("rst_done",    {31'b0, o_done},       32'd0);
    chk("rst_ena",     {31'b0, o_scanclkena}, 32'd0);
    chk("rst_sdata",   {31'b0, o_scandata},   32'd0);
    chk("rst_data_rd", {24'b0, o_data_rd},    32'd0);
    chk("rst_valid",   {31'b0, o_rd_valid},   32'd0);
    i_reset_n = 1'b1;
    do_read(0, 8'h00, "rst_rd0");

    // 0xA5 pattern; reads during the shift still see the reset snapshot
    preload(a5);
    readback(0, 1'b0, 1'b1, 8'h00, "a5");
    do_read(0,  8'hA5, "a5_rd0");
    do_read(19, 8'h25, "a5_rd19");

    // walking one with ignored extra starts; read coinciding with DONE sees 0xA5
    preload(walk);
    readback(0, 1'b1, 1'b1, 8'hA5, "walk");
    read_all(walk, "walk");
    do_read(25, 8'h00, "walk_rd25");

    // back-to-back read-backs
`ifdef PLL_SCAN_RD_RESTORE_EN
    exp2 = p;
`else
    exp2 = '0;
`endif
    preload(p);
    readback(0, 1'b0, 1'b0, 8'h00, "bb1");
    read_all(p, "bb1");
    readback(0, 1'b0, 1'b0, 8'h00, "bb2");
    read_all(exp2, "bb2");
    cpad = {2'b00, chain};
    epad = {2'b00, exp2};
    for (int w = 0; w < 5; w++)
      chk($sformatf("chain_w%0d", w), cpad[32*w +: 32], epad[32*w +: 32]);

    // reset in the middle of the shift
    preload(a5);
    readback(80, 1'b0, 1'b0, 8'h00, "abort");
    do_read(0, 8'h00, "abort_rd0");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
